// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: safety monitor between traffic_control and the lamp drivers.
// Checks the four lamp vectors for illegal codes, conflicting greens, illegal
// transitions, short yellow and stalled phases. Legal samples are forwarded one
// cycle later; any fault latches a cause code and flashes all lamps RED/OFF
// until fault_clr is seen together with all inputs RED.
// Optional: define MON_GREEN_COUNT_EN to count accepted GREEN->YELLOW transitions.
// Ports:
//   clk, rst_a                     clock, synchronous active-high reset
//   {n,s,e,w}_lights_in [2:0]      lamp states from traffic_control
//   fault_clr                      leave FAULT (only when all inputs RED)
//   {n,s,e,w}_lights_out [2:0]     registered lamp drive
//   fault, fault_code [2:0]        fault flag and latched cause (0 = none)
//   green_count [15:0]             completed green phases (0 when feature off)
module traffic_light_monitor #(
  parameter int unsigned MIN_YELLOW = 3,
  parameter int unsigned MAX_PHASE  = 200,
  parameter int unsigned FLASH_HALF = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_a,
  input  logic [2:0]  n_lights_in,
  input  logic [2:0]  s_lights_in,
  input  logic [2:0]  e_lights_in,
  input  logic [2:0]  w_lights_in,
  input  logic        fault_clr,
  output logic [2:0]  n_lights_out,
  output logic [2:0]  s_lights_out,
  output logic [2:0]  e_lights_out,
  output logic [2:0]  w_lights_out,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [15:0] green_count
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;
  localparam logic [11:0] ALL_RED = {RED, RED, RED, RED};
  localparam logic [11:0] ALL_OFF = {OFF, OFF, OFF, OFF};

  typedef enum logic [1:0] {S_INIT, S_RUN, S_FAULT} state_t;

  state_t state, state_next;

  // Index 3 = north, 2 = south, 1 = east, 0 = west
  logic [3:0][2:0]       cur, prev_q, prev_d;
  logic [3:0][2:0]       out_q, out_d;
  logic [3:0][CNT_W-1:0] dwell_q, dwell_d, dwell_inc;
  logic [CNT_W-1:0]      stall_q, stall_d, stall_inc;
  logic [CNT_W-1:0]      flash_cnt_q, flash_cnt_d;
  logic                  flash_off_q, flash_off_d;
  logic                  fault_q, fault_d;
  logic [2:0]            code_q, code_d;
  logic [2:0]            cause;
  logic                  clr_ok;

  assign cur = {n_lights_in, s_lights_in, e_lights_in, w_lights_in};
  assign clr_ok = fault_clr && (cur == ALL_RED);

  // Fault cause evaluation against the previous sample; lowest code wins
  always_comb begin
    logic       illegal, seq_bad, short_y, stall;
    logic [2:0] nr_cnt;
    illegal = 1'b0;
    seq_bad = 1'b0;
    short_y = 1'b0;
    nr_cnt  = 3'd0;
    for (int d = 0; d < 4; d++) begin
      if (!(cur[d] == RED || cur[d] == YEL || cur[d] == GRN)) illegal = 1'b1;
      if (cur[d] != RED) nr_cnt = nr_cnt + 3'd1;
      if (cur[d] != prev_q[d] &&
          !((prev_q[d] == RED && cur[d] == GRN) ||
            (prev_q[d] == GRN && cur[d] == YEL) ||
            (prev_q[d] == YEL && cur[d] == RED))) seq_bad = 1'b1;
      if (prev_q[d] == YEL && cur[d] == RED && dwell_q[d] < CNT_W'(MIN_YELLOW)) short_y = 1'b1;
      dwell_inc[d] = (cur[d] != YEL) ? '0 :
                     (dwell_q[d] >= CNT_W'(MIN_YELLOW)) ? dwell_q[d] : dwell_q[d] + CNT_W'(1);
    end
    stall_inc = (cur != prev_q) ? '0 :
                (stall_q >= CNT_W'(MAX_PHASE)) ? stall_q : stall_q + CNT_W'(1);
    stall = (stall_inc >= CNT_W'(MAX_PHASE));
    if      (illegal)          cause = 3'd1;
    else if (nr_cnt >= 3'd2)   cause = 3'd2;
    else if (seq_bad)          cause = 3'd3;
    else if (short_y)          cause = 3'd4;
    else if (stall)            cause = 3'd5;
    else                       cause = 3'd0;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst_a) state <= S_INIT;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_INIT:  state_next = S_RUN;
      S_RUN:   if (cause != 3'd0) state_next = S_FAULT;
      S_FAULT: if (clr_ok) state_next = S_INIT;
      default: state_next = S_INIT;
    endcase
  end

  // Next values of the registered outputs and monitor datapath
  always_comb begin
    out_d       = out_q;
    prev_d      = prev_q;
    dwell_d     = dwell_q;
    stall_d     = stall_q;
    flash_cnt_d = flash_cnt_q;
    flash_off_d = flash_off_q;
    fault_d     = fault_q;
    code_d      = code_q;
    case (state)
      S_INIT: begin
        prev_d  = cur;
        dwell_d = dwell_inc;
        stall_d = '0;
        out_d   = ALL_RED;
      end
      S_RUN: begin
        prev_d = cur;
        if (cause != 3'd0) begin
          // Offending sample is dropped; flash starts in its RED half
          fault_d     = 1'b1;
          code_d      = cause;
          out_d       = ALL_RED;
          flash_cnt_d = '0;
          flash_off_d = 1'b0;
          dwell_d     = '0;
          stall_d     = '0;
        end else begin
          out_d   = cur;
          dwell_d = dwell_inc;
          stall_d = stall_inc;
        end
      end
      S_FAULT: begin
        if (clr_ok) begin
          fault_d = 1'b0;
          code_d  = 3'd0;
          out_d   = ALL_RED;
        end else begin
          if (flash_cnt_q >= CNT_W'(FLASH_HALF - 1)) begin
            flash_cnt_d = '0;
            flash_off_d = ~flash_off_q;
          end else begin
            flash_cnt_d = flash_cnt_q + CNT_W'(1);
          end
          out_d = flash_off_d ? ALL_OFF : ALL_RED;
        end
      end
      default: out_d = ALL_RED;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst_a) begin
      out_q       <= ALL_RED;
      prev_q      <= '0;
      dwell_q     <= '0;
      stall_q     <= '0;
      flash_cnt_q <= '0;
      flash_off_q <= 1'b0;
      fault_q     <= 1'b0;
      code_q      <= 3'd0;
    end else begin
      out_q       <= out_d;
      prev_q      <= prev_d;
      dwell_q     <= dwell_d;
      stall_q     <= stall_d;
      flash_cnt_q <= flash_cnt_d;
      flash_off_q <= flash_off_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
    end
  end

  assign n_lights_out = out_q[3];
  assign s_lights_out = out_q[2];
  assign e_lights_out = out_q[1];
  assign w_lights_out = out_q[0];
  assign fault        = fault_q;
  assign fault_code   = code_q;

`ifdef MON_GREEN_COUNT_EN
  logic        g2y;
  logic [15:0] gc_q;

  // At most one direction can go GREEN->YELLOW in an accepted cycle
  always_comb begin
    g2y = 1'b0;
    for (int d = 0; d < 4; d++)
      if (prev_q[d] == GRN && cur[d] == YEL) g2y = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_a)
      gc_q <= 16'h0000;
    else if (state == S_RUN && cause == 3'd0 && g2y && gc_q != 16'hFFFF)
      gc_q <= gc_q + 16'd1;
  end

  assign green_count = gc_q;
`else
  assign green_count = 16'h0000;
`endif

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Safety monitor sitting directly downstream of traffic_control. It samples the four 3-bit lamp vectors and checks them for illegal encodings, conflicting greens, skipped yellow, short yellow and stalled phases. It forwards legal lamp states to the lamp drivers one cycle later. On any fault it latches a fault code and forces all four directions to flashing red until the fault is cleared.

Parameters:
MIN_YELLOW, 3, minimum consecutive cycles a direction must show YELLOW before going RED
MAX_PHASE, 200, cycles with no lamp change on any direction before a stall fault
FLASH_HALF, 4, cycles per half-period of the fault flash (RED, then OFF)
CNT_W, 8, width of the internal dwell/stall counters; must hold MAX_PHASE

Ports:
clk  input  1  system clock, rising edge
rst_a  input  1  synchronous active-high reset
n_lights_in  input  3  north lamp state from traffic_control
s_lights_in  input  3  south lamp state
e_lights_in  input  3  east lamp state
w_lights_in  input  3  west lamp state
fault_clr  input  1  request to leave FAULT; honoured only when all inputs are RED
n_lights_out  output  3  north lamp drive (registered)
s_lights_out  output  3  south lamp drive
e_lights_out  output  3  east lamp drive
w_lights_out  output  3  west lamp drive
fault  output  1  high while in FAULT
fault_code  output  3  latched cause of the fault; 0 when no fault
green_count  output  16  completed green phases (see Optional Feature)

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst_a.
- Lamp encoding: RED=3'b100, YELLOW=3'b010, GREEN=3'b001, OFF=3'b000. OFF is legal only as a lamp output.
- Reset values:
  - all *_lights_out = RED; fault=0; fault_code=0; green_count=0; state=S_INIT.
  - dwell/stall counters, previous-sample registers and flash phase are all cleared.
- S_INIT:
  - Captures the inputs as the previous sample.
  - Outputs remain RED.
  - Moves to S_RUN next cycle unconditionally.
- S_RUN: each cycle, checks the current inputs against the previous sample. Causes, checked in this priority (lowest code wins if several hit in one cycle):
  - 1 ILLEGAL: any input not in {RED, YELLOW, GREEN}.
  - 2 CONFLICT: two or more directions non-RED at once.
  - 3 SEQUENCE: any direction takes a transition other than hold, RED->GREEN, GREEN->YELLOW or YELLOW->RED.
  - 4 SHORT_YELLOW: YELLOW->RED after fewer than MIN_YELLOW consecutive YELLOW cycles on that direction.
  - 5 STALL: no input changes for MAX_PHASE consecutive cycles. The stall counter resets on any change and saturates.
- S_RUN, no fault: *_lights_out <= inputs (1-cycle latency).
- S_RUN, any fault: state <= S_FAULT, fault <= 1 and fault_code <= cause, all in the same edge. The offending sample is never forwarded; outputs go straight to flash phase RED.
- S_FAULT:
  - All four outputs flash together: RED for FLASH_HALF cycles, then OFF for FLASH_HALF cycles, repeating.
  - Further fault causes are ignored; fault_code holds the first cause.
- Leaving S_FAULT:
  - If fault_clr=1 and all four inputs are RED in the same cycle: state <= S_INIT, fault <= 0, fault_code <= 0, outputs <= RED.
  - fault_clr is ignored in S_INIT and S_RUN.
- rst_a mid-operation, including during FAULT: immediate return to the reset values on the next edge.
- Yellow dwell: one counter per direction, saturating at MIN_YELLOW. It counts while that direction is YELLOW and clears when the direction is not YELLOW.

Optional Feature:
Macro MON_GREEN_COUNT_EN.
- Defined: green_count increments by 1 on each accepted GREEN->YELLOW transition in S_RUN, for any direction. It saturates at 16'hFFFF, is cleared only by rst_a, and holds its value through FAULT.
- Undefined: the counter logic is omitted and green_count is tied to 16'h0000.

Test Plan:
1. Legal sequence: reset for 2 cycles; N driven GREEN 10 cycles, YELLOW 3, RED, then E the same way -> outputs match inputs delayed 1 cycle; fault=0 throughout; green_count=2 with MON_GREEN_COUNT_EN.
2. Conflict: N=GREEN and E=GREEN in the same cycle -> next edge fault=1, fault_code=2; outputs alternate 4 cycles 3'b100 and 4 cycles 3'b000 on all four directions.
3. Short yellow: N GREEN->YELLOW for 2 cycles ->RED -> fault_code=4. Repeat with YELLOW held 3 cycles -> no fault.
4. Skip and illegal: N GREEN->RED directly -> fault_code=3. Separately, W=3'b011 -> fault_code=1. Apply 3'b011 together with a conflict -> fault_code=1 (priority).
5. Stall: hold all inputs constant for 200 cycles from S_RUN entry -> fault_code=5. Changing an input at cycle 199 -> no fault.
6. Clear and reset: in FAULT, fault_clr=1 with N=GREEN -> stays in FAULT. Then all inputs RED and fault_clr=1 -> fault=0, outputs RED, normal forwarding resumes. Separately, assert rst_a mid-flash -> all outputs RED and fault=0 after one edge.
